// File: rtl/flash_op_pkg.sv
// Shared types and constants for the flash operation arbiter.
// Holds the operation type codes, the arbiter state encoding and the
// interface field widths used by flash_op_arbiter and its sub-module.
package flash_op_pkg;

  localparam int unsigned P_TYPE_W = 2;
  localparam int unsigned P_ADDR_W = 24;
  localparam int unsigned P_NUM_W  = 9;
  localparam int unsigned P_DATA_W = 8;

  localparam logic [P_TYPE_W-1:0] P_TYPE_CLEAR = 2'd0;
  localparam logic [P_TYPE_W-1:0] P_TYPE_WRITE = 2'd1;
  localparam logic [P_TYPE_W-1:0] P_TYPE_READ  = 2'd2;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin priority select.
// Ports:
//   i_valid - request vector, one bit per requester
//   i_ptr   - index of the last winner; search starts at i_ptr+1 and wraps
//   o_sel   - index of the first set request found (0 when none)
//   o_any   - at least one request is set
// Purely combinational.
module rr_arbiter_n #(
  parameter int unsigned P_N = 2,
  parameter int unsigned P_W = 1
) (
  input  logic [P_N-1:0] i_valid,
  input  logic [P_W-1:0] i_ptr,
  output logic [P_W-1:0] o_sel,
  output logic           o_any
);

  // One extra bit so ptr + offset (at most 2*P_N-1) never overflows.
  logic [P_W:0] w_idx;

  always_comb begin
    o_sel = '0;
    o_any = |i_valid;
    w_idx = '0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int off = int'(P_N); off >= 1; off--) begin
      w_idx = {1'b0, i_ptr} + (P_W+1)'(off);
      if (w_idx >= (P_W+1)'(P_N)) begin
        w_idx = w_idx - (P_W+1)'(P_N);
      end
      if (i_valid[w_idx[P_W-1:0]]) begin
        o_sel = w_idx[P_W-1:0];
      end
    end
  end

endmodule

// File: rtl/flash_op_arbiter.sv
// Shares one flash driver op/write/read interface among P_USER_NUM requesters.
// Ports:
//   i_u_op_*  / o_u_op_ready - per-requester operation request, packed per requester
//   i_u_wr_*                 - per-requester write stream
//   o_u_rd_*                 - read stream back to the granted requester (data broadcast)
//   o_op_*    / i_op_ready   - operation interface to the driver
//   o_wr_*                   - write stream to the driver
//   i_rd_*                   - read stream from the driver
//   o_grant                  - index of the current/last granted requester
// A grant is taken at the op handshake and held until the driver's ready has
// gone low and come back high, which marks the operation complete.
module flash_op_arbiter
  import flash_op_pkg::*;
#(
  parameter int unsigned P_USER_NUM = 2,
  parameter int unsigned P_GRANT_W  = $clog2(P_USER_NUM)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [P_TYPE_W*P_USER_NUM-1:0]   i_u_op_type,
  input  logic [P_ADDR_W*P_USER_NUM-1:0]   i_u_op_addr,
  input  logic [P_NUM_W*P_USER_NUM-1:0]    i_u_op_num,
  input  logic [P_USER_NUM-1:0]            i_u_op_valid,
  output logic [P_USER_NUM-1:0]            o_u_op_ready,
  input  logic [P_DATA_W*P_USER_NUM-1:0]   i_u_wr_data,
  input  logic [P_USER_NUM-1:0]            i_u_wr_sop,
  input  logic [P_USER_NUM-1:0]            i_u_wr_eop,
  input  logic [P_USER_NUM-1:0]            i_u_wr_valid,
  output logic [P_DATA_W-1:0]              o_u_rd_data,
  output logic [P_USER_NUM-1:0]            o_u_rd_sop,
  output logic [P_USER_NUM-1:0]            o_u_rd_eop,
  output logic [P_USER_NUM-1:0]            o_u_rd_valid,
  output logic [P_TYPE_W-1:0]              o_op_type,
  output logic [P_ADDR_W-1:0]              o_op_addr,
  output logic [P_NUM_W-1:0]               o_op_num,
  output logic                             o_op_valid,
  input  logic                             i_op_ready,
  output logic [P_DATA_W-1:0]              o_wr_data,
  output logic                             o_wr_sop,
  output logic                             o_wr_eop,
  output logic                             o_wr_valid,
  input  logic [P_DATA_W-1:0]              i_rd_data,
  input  logic                             i_rd_sop,
  input  logic                             i_rd_eop,
  input  logic                             i_rd_valid,
  output logic [P_GRANT_W-1:0]             o_grant
);

  arb_state_e             r_state, w_state_nxt;
  logic [P_GRANT_W-1:0]   r_ptr;
  logic [P_GRANT_W-1:0]   r_grant;
  logic                   r_seen_low;

  logic [P_GRANT_W-1:0]   w_sel;
  logic                   w_any;
  logic                   w_idle;
  logic                   w_hs;
  logic                   w_wr_en;
  logic [P_GRANT_W-1:0]   w_wr_idx;
  logic [P_USER_NUM-1:0]  w_gnt_oh;

  logic [P_TYPE_W-1:0]    w_u_type  [P_USER_NUM];
  logic [P_ADDR_W-1:0]    w_u_addr  [P_USER_NUM];
  logic [P_NUM_W-1:0]     w_u_num   [P_USER_NUM];
  logic [P_DATA_W-1:0]    w_u_wdata [P_USER_NUM];

  rr_arbiter_n #(
    .P_N (P_USER_NUM),
    .P_W (P_GRANT_W)
  ) u_rr (
    .i_valid (i_u_op_valid),
    .i_ptr   (r_ptr),
    .o_sel   (w_sel),
    .o_any   (w_any)
  );

  // Unpack the per-requester fields.
  always_comb begin
    for (int k = 0; k < int'(P_USER_NUM); k++) begin
      w_u_type[k]  = i_u_op_type[k*P_TYPE_W +: P_TYPE_W];
      w_u_addr[k]  = i_u_op_addr[k*P_ADDR_W +: P_ADDR_W];
      w_u_num[k]   = i_u_op_num[k*P_NUM_W +: P_NUM_W];
      w_u_wdata[k] = i_u_wr_data[k*P_DATA_W +: P_DATA_W];
    end
  end

  assign w_idle = (r_state == StIdle);
  // valid[sel] is implied by w_any, and ready[sel] reduces to idle & i_op_ready.
  assign w_hs   = w_idle & i_op_ready & w_any;

  // With no request pending every ready is high, so each requester sees a
  // rising edge when the driver completes.
  always_comb begin
    o_u_op_ready = '0;
    w_gnt_oh     = '0;
    for (int k = 0; k < int'(P_USER_NUM); k++) begin
      o_u_op_ready[k] = w_idle & i_op_ready & (~w_any | (w_sel == P_GRANT_W'(k)));
      w_gnt_oh[k]     = (r_grant == P_GRANT_W'(k));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_hs) w_state_nxt = StBusy;
      StBusy:  if (r_seen_low && i_op_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_ptr      <= P_GRANT_W'(P_USER_NUM - 1);
      r_grant    <= '0;
      r_seen_low <= 1'b0;
      o_op_valid <= 1'b0;
      o_op_type  <= '0;
      o_op_addr  <= '0;
      o_op_num   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      o_op_valid <= w_hs;
      if (w_hs) begin
        r_grant    <= w_sel;
        r_ptr      <= w_sel;
        r_seen_low <= 1'b0;
        o_op_type  <= w_u_type[w_sel];
        o_op_addr  <= w_u_addr[w_sel];
        o_op_num   <= w_u_num[w_sel];
      end else if (!w_idle && !i_op_ready) begin
        r_seen_low <= 1'b1;
      end
    end
  end

  // The handshake cycle already forwards the winner's beats, so the
  // request-to-data spacing matches a direct connection.
  assign w_wr_en  = w_hs | ~w_idle;
  assign w_wr_idx = w_hs ? w_sel : r_grant;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_data    <= '0;
      o_wr_sop     <= 1'b0;
      o_wr_eop     <= 1'b0;
      o_wr_valid   <= 1'b0;
      o_u_rd_data  <= '0;
      o_u_rd_sop   <= '0;
      o_u_rd_eop   <= '0;
      o_u_rd_valid <= '0;
    end else begin
      o_wr_data    <= w_wr_en ? w_u_wdata[w_wr_idx] : '0;
      o_wr_sop     <= w_wr_en & i_u_wr_sop[w_wr_idx];
      o_wr_eop     <= w_wr_en & i_u_wr_eop[w_wr_idx];
      o_wr_valid   <= w_wr_en & i_u_wr_valid[w_wr_idx];
      // Grant holds past completion, so late read beats still route correctly.
      o_u_rd_data  <= i_rd_data;
      o_u_rd_sop   <= w_gnt_oh & {P_USER_NUM{i_rd_sop}};
      o_u_rd_eop   <= w_gnt_oh & {P_USER_NUM{i_rd_eop}};
      o_u_rd_valid <= w_gnt_oh & {P_USER_NUM{i_rd_valid}};
    end
  end

  assign o_grant = r_grant;

endmodule

// File: tb/tb_flash_op_arbiter.sv
// Scoreboard bench for flash_op_arbiter with two requesters.
module tb_flash_op_arbiter;
  import flash_op_pkg::*;

  localparam int N  = 2;
  localparam int GW = 1;

  typedef struct {
    int          cyc;
    logic [1:0]  typ;
    logic [23:0] addr;
    logic [8:0]  num;
    int          gnt;
  } op_exp_t;

  typedef struct {
    int         cyc;
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } wr_exp_t;

  typedef struct {
    int           cyc;
    logic [N-1:0] vld;
    logic [N-1:0] sop;
    logic [N-1:0] eop;
    logic [7:0]   data;
  } rd_exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2*N-1:0]  u_op_type = '0;
  logic [24*N-1:0] u_op_addr = '0;
  logic [9*N-1:0]  u_op_num = '0;
  logic [N-1:0]    u_op_valid = '0;
  logic [N-1:0]    o_u_op_ready;
  logic [8*N-1:0]  u_wr_data = '0;
  logic [N-1:0]    u_wr_sop = '0;
  logic [N-1:0]    u_wr_eop = '0;
  logic [N-1:0]    u_wr_valid = '0;
  logic [7:0]      o_u_rd_data;
  logic [N-1:0]    o_u_rd_sop, o_u_rd_eop, o_u_rd_valid;
  logic [1:0]      o_op_type;
  logic [23:0]     o_op_addr;
  logic [8:0]      o_op_num;
  logic            o_op_valid;
  logic            op_ready = 1'b1;
  logic [7:0]      o_wr_data;
  logic            o_wr_sop, o_wr_eop, o_wr_valid;
  logic [7:0]      rd_data = '0;
  logic            rd_sop = 1'b0;
  logic            rd_eop = 1'b0;
  logic            rd_valid = 1'b0;
  logic [GW-1:0]   o_grant;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  op_exp_t op_q[$];
  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];
  op_exp_t m_op;
  wr_exp_t m_wr;
  rd_exp_t m_rd;

  flash_op_arbiter #(
    .P_USER_NUM (N),
    .P_GRANT_W  (GW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_u_op_type  (u_op_type),
    .i_u_op_addr  (u_op_addr),
    .i_u_op_num   (u_op_num),
    .i_u_op_valid (u_op_valid),
    .o_u_op_ready (o_u_op_ready),
    .i_u_wr_data  (u_wr_data),
    .i_u_wr_sop   (u_wr_sop),
    .i_u_wr_eop   (u_wr_eop),
    .i_u_wr_valid (u_wr_valid),
    .o_u_rd_data  (o_u_rd_data),
    .o_u_rd_sop   (o_u_rd_sop),
    .o_u_rd_eop   (o_u_rd_eop),
    .o_u_rd_valid (o_u_rd_valid),
    .o_op_type    (o_op_type),
    .o_op_addr    (o_op_addr),
    .o_op_num     (o_op_num),
    .o_op_valid   (o_op_valid),
    .i_op_ready   (op_ready),
    .o_wr_data    (o_wr_data),
    .o_wr_sop     (o_wr_sop),
    .o_wr_eop     (o_wr_eop),
    .o_wr_valid   (o_wr_valid),
    .i_rd_data    (rd_data),
    .i_rd_sop     (rd_sop),
    .i_rd_eop     (rd_eop),
    .i_rd_valid   (rd_valid),
    .o_grant      (o_grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every beat the DUT produces must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_op_valid) begin
        if (op_q.size() == 0) begin
          check("op_unexpected", 64'(op_q.size()), 1);
        end else begin
          m_op = op_q.pop_front();
          check("op_cyc", cyc, m_op.cyc);
          check("op_type", o_op_type, m_op.typ);
          check("op_addr", o_op_addr, m_op.addr);
          check("op_num", o_op_num, m_op.num);
          check("op_grant", o_grant, m_op.gnt);
        end
      end
      if (o_wr_valid) begin
        if (wr_q.size() == 0) begin
          check("wr_unexpected", 64'(wr_q.size()), 1);
        end else begin
          m_wr = wr_q.pop_front();
          check("wr_cyc", cyc, m_wr.cyc);
          check("wr_data", o_wr_data, m_wr.data);
          check("wr_sop", o_wr_sop, m_wr.sop);
          check("wr_eop", o_wr_eop, m_wr.eop);
        end
      end
      if (|o_u_rd_valid) begin
        if (rd_q.size() == 0) begin
          check("rd_unexpected", 64'(rd_q.size()), 1);
        end else begin
          m_rd = rd_q.pop_front();
          check("rd_cyc", cyc, m_rd.cyc);
          check("rd_valid", o_u_rd_valid, m_rd.vld);
          check("rd_sop", o_u_rd_sop, m_rd.sop);
          check("rd_eop", o_u_rd_eop, m_rd.eop);
          check("rd_data", o_u_rd_data, m_rd.data);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Ends settled (#1 after driving) so wait_hs can sample immediately.
  task automatic set_req(input int k, input logic [1:0] t, input logic [23:0] a,
                         input logic [8:0] n);
    u_op_type[k*2 +: 2]  = t;
    u_op_addr[k*24 +: 24] = a;
    u_op_num[k*9 +: 9]   = n;
    u_op_valid[k]        = 1'b1;
    #1;
  endtask

  task automatic wait_hs(input int k, output int waited, output logic [N-1:0] seen);
    waited = 0;
    seen   = '0;
    while (!(o_u_op_ready[k] && u_op_valid[k]) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!(o_u_op_ready[k] && u_op_valid[k])) begin
      check("hs_ready", 64'(o_u_op_ready[k]), 1);
      u_op_valid[k] = 1'b0;
      return;
    end
    seen = o_u_op_ready;
    @(posedge clk); #1;
    op_q.push_back('{cyc, u_op_type[k*2 +: 2], u_op_addr[k*24 +: 24], u_op_num[k*9 +: 9], k});
    u_op_valid[k] = 1'b0;
  endtask

  task automatic send_wr(input int k, input int nb, input int base, input bit noise);
    for (int i = 0; i < nb; i++) begin
      u_wr_data[k*8 +: 8] = 8'(base + i);
      u_wr_sop[k]   = (i == 0);
      u_wr_eop[k]   = (i == nb - 1);
      u_wr_valid[k] = 1'b1;
      if (noise) begin
        u_wr_data[(1-k)*8 +: 8] = 8'(8'h50 + i);
        u_wr_sop[1-k]   = (i == 0);
        u_wr_eop[1-k]   = (i == nb - 1);
        u_wr_valid[1-k] = 1'b1;
      end
      wr_q.push_back('{cyc + 1, (i == 0), (i == nb - 1), 8'(base + i)});
      @(posedge clk); #1;
    end
    u_wr_valid = '0;
    u_wr_sop   = '0;
    u_wr_eop   = '0;
  endtask

  task automatic send_rd(input int k, input int nb, input int base);
    logic [N-1:0] oh;
    oh    = '0;
    oh[k] = 1'b1;
    for (int i = 0; i < nb; i++) begin
      rd_data  = 8'(base + i);
      rd_sop   = (i == 0);
      rd_eop   = (i == nb - 1);
      rd_valid = 1'b1;
      rd_q.push_back('{cyc + 1, oh, (i == 0) ? oh : '0, (i == nb - 1) ? oh : '0,
                      8'(base + i)});
      @(posedge clk); #1;
    end
    rd_valid = 1'b0;
    rd_sop   = 1'b0;
    rd_eop   = 1'b0;
  endtask

  // Driver goes busy for 3 cycles then ready again; returns at a negedge.
  task automatic complete_op(input logic [N-1:0] exp_rdy);
    @(posedge clk); #1 op_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 op_ready = 1'b1;
    @(negedge clk) check("rdy_busy", o_u_op_ready, '0);
    @(negedge clk) check("rdy_done", o_u_op_ready, exp_rdy);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    int waited;
    logic [N-1:0] seen;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_grant", o_grant, 0);
    check("rst_op_valid", o_op_valid, 0);
    check("rst_wr_valid", o_wr_valid, 0);
    check("rst_rd_valid", o_u_rd_valid, 0);
    check("rst_ready", o_u_op_ready, 2'b11);

    // u0 write of 8 bytes.
    set_req(0, P_TYPE_WRITE, 24'h000000, 9'd8);
    wait_hs(0, waited, seen);
    check("t1_seen", seen, 2'b11 & 2'b01 | (seen & 2'b10));
    check("t1_grant", o_grant, 0);
    send_wr(0, 8, 8'h10, 1'b0);
    complete_op(2'b11);

    // Two simultaneous requesters after reset, then rotation.
    do_reset();
    set_req(0, P_TYPE_WRITE, 24'h001000, 9'd4);
    set_req(1, P_TYPE_READ, 24'h002000, 9'd4);
    wait_hs(0, waited, seen);
    check("t2_seen_u0", seen, 2'b01);
    complete_op(2'b10);
    wait_hs(1, waited, seen);
    check("t2_seen_u1", seen, 2'b10);
    check("t2_grant_u1", o_grant, 1);
    complete_op(2'b11);
    set_req(0, P_TYPE_CLEAR, 24'h003000, 9'd0);
    set_req(1, P_TYPE_CLEAR, 24'h004000, 9'd0);
    wait_hs(0, waited, seen);
    check("t2_rot_seen", seen, 2'b01);
    complete_op(2'b10);
    wait_hs(1, waited, seen);
    complete_op(2'b11);

    // u1 read of 8 bytes; nothing routes to u0.
    do_reset();
    set_req(1, P_TYPE_READ, 24'h00ABCD, 9'd8);
    wait_hs(1, waited, seen);
    check("t3_grant", o_grant, 1);
    send_rd(1, 8, 8'hC0);
    complete_op(2'b11);

    // Driver busy before the request: it must wait, then go at once.
    op_ready = 1'b0;
    set_req(0, P_TYPE_CLEAR, 24'h123456, 9'd0);
    repeat (3) begin
      @(negedge clk);
      check("t4_rdy_low", o_u_op_ready[0], 0);
      check("t4_no_op", o_op_valid, 0);
    end
    op_ready = 1'b1;
    #1;
    wait_hs(0, waited, seen);
    check("t4_hs_wait", waited, 0);
    complete_op(2'b11);

    // u1 noise on the write stream while u0 owns a write.
    set_req(0, P_TYPE_WRITE, 24'h000100, 9'd4);
    wait_hs(0, waited, seen);
    send_wr(0, 4, 8'hA0, 1'b1);
    complete_op(2'b11);
    u_wr_valid[1] = 1'b1;
    u_wr_data[15:8] = 8'h77;
    repeat (2) @(negedge clk);
    check("t5_idle_drop", o_wr_valid, 0);
    u_wr_valid = '0;

    // Reset in the middle of a busy read.
    set_req(1, P_TYPE_READ, 24'h00BEEF, 9'd16);
    wait_hs(1, waited, seen);
    op_ready = 1'b0;
    rd_data = 8'h3C;
    rd_valid = 1'b1;
    rd_q.push_back('{cyc + 1, 2'b10, 2'b00, 2'b00, 8'h3C});
    @(posedge clk); #1;
    rd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_grant", o_grant, 0);
    check("t6_op_type", o_op_type, 0);
    check("t6_op_addr", o_op_addr, 0);
    check("t6_op_num", o_op_num, 0);
    check("t6_rd_data", o_u_rd_data, 0);
    op_ready = 1'b1;
    #1;
    check("t6_idle", o_u_op_ready, 2'b11);
    @(posedge clk); #1 rst_n = 1'b1;
    set_req(0, P_TYPE_READ, 24'h000055, 9'd2);
    set_req(1, P_TYPE_READ, 24'h000066, 9'd2);
    wait_hs(0, waited, seen);
    check("t6_seen", seen, 2'b01);
    check("t6_grant_u0", o_grant, 0);
    u_op_valid[1] = 1'b0;
    complete_op(2'b11);

    repeat (2) @(posedge clk);
    check("q_op_empty", 64'(op_q.size()), 0);
    check("q_wr_empty", 64'(wr_q.size()), 0);
    check("q_rd_empty", 64'(rd_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
